// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared constants for the multi-cycle MIPS controller.
//   Contents: opcode values, ALU function codes, mux select codes,
//   the state encoding, the bundled control-output struct and the
//   legal-opcode helper used by both next-state and output decode.
package mc_ctrl_pkg;

  localparam int ALUOP_W = 6;
  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 6'b100000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 6'b100010;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Codes 13..15 are unused; they recover to FETCH with all outputs low.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_LW_WB    = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  typedef struct packed {
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode
//   Purely combinational map from the registered controller state to the
//   datapath control bundle.
// Ports
//   state_i      current state
//   mem_ready_i  memory handshake (only qualifies IRWrite/PCWrite in FETCH)
//   opcode_i     Instruction[31:26], flags illegal opcodes in DECODE
//   funct_i      Instruction[5:0], passed to ALUOp in EXEC_R
//   ctrl_o       control bundle; all zero for IDLE and unused encodings
module mc_output_decode
  import mc_ctrl_pkg::*;
(
  input  state_e             state_i,
  input  logic               mem_ready_i,
  input  logic [5:0]         opcode_i,
  input  logic [ALUOP_W-1:0] funct_i,
  output ctrl_t              ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        // IR and PC only commit in the cycle the memory returns data.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.illegal_op = !is_legal_op(opcode_i);
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_LW_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = funct_i;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multi-cycle MIPS datapath with a single memory port.
//   Holds the state register and next-state logic; outputs are decoded
//   from the registered state by mc_output_decode.
// Ports
//   Clk, Rst            clock (rising edge), async active-low reset
//   Instruction         IR contents (opcode [31:26], funct [5:0])
//   ALUZero             ALU zero flag, consumed by the datapath via PCWriteCond
//   MemReady            memory access complete this cycle
//   IorD..RegWrite      datapath mux selects and write enables
//   IllegalOp           pulse while DECODE holds an unsupported opcode
//   State               current state, debug
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | after reset, no outputs
// FETCH    | read instruction at PC, PC+4; waits on MemReady
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | effective address for LW/SW
// MEM_RD   | load read; waits on MemReady
// LW_WB    | MDR into rt
// MEM_WR   | store write; waits on MemReady
// EXEC_R   | R-type ALU op from funct
// R_WB     | ALUOut into rd
// EXEC_I   | ADDI: A + sext imm
// I_WB     | ALUOut into rt
// BRANCH   | BEQ compare, PC <- ALUOut on zero
// JUMP     | PC <- jump target
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic [31:0]        Instruction,
  input  logic               ALUZero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  state_e     state_q, state_d;
  // LW/SW choice is latched in DECODE so MEM_ADDR does not depend on the IR.
  logic       is_store_q, is_store_d;
  logic [5:0] opcode;
  ctrl_t      ctrl;

  // ALUZero is applied by the datapath (PCWriteCond); the middle IR bits
  // are datapath operands.
  logic unused_inputs;
  assign unused_inputs = ALUZero ^ (^Instruction[25:6]);

  assign opcode = Instruction[31:26];

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        is_store_d = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (MemReady) state_d = S_LW_WB;
      S_MEM_WR:   if (MemReady) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_LW_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:
                  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  mc_output_decode u_output_decode (
    .state_i     (state_q),
    .mem_ready_i (MemReady),
    .opcode_i    (opcode),
    .funct_i     (Instruction[5:0]),
    .ctrl_o      (ctrl)
  );

  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign IllegalOp   = ctrl.illegal_op;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed reset/stall sequences,
// a per-instruction table of latency and enable counts, and randomized
// instruction streams checked cycle by cycle against a phase-list model.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] Instruction = 32'h0;
  logic        ALUZero = 1'b0;
  logic        MemReady = 1'b0;
  logic        IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic [1:0]  PCSource, ALUSrcB;
  logic        ALUSrcA, RegDst, MemtoReg, RegWrite, IllegalOp;
  logic [5:0]  ALUOp;
  logic [3:0]  State;

  multicycle_controller dut (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .ALUZero(ALUZero),
    .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .IllegalOp(IllegalOp), .State(State)
  );

  always #5 Clk = ~Clk;

  logic [20:0] ctl_w;
  assign ctl_w = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource,
                  ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, IllegalOp};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [20:0] pk(
    input logic iord, input logic mrd, input logic mwr, input logic irw,
    input logic pcw, input logic pcwc, input logic [1:0] pcs, input logic asa,
    input logic [1:0] asb, input logic [5:0] aop, input logic rdst,
    input logic m2r, input logic rw, input logic ill);
    return {iord, mrd, mwr, irw, pcw, pcwc, pcs, asa, asb, aop, rdst, m2r, rw, ill};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  endfunction

  typedef struct {
    logic        rdy;
    logic        jam;   // drive junk on Instruction: IR must not matter here
    logic [3:0]  st;
    logic [20:0] ctl;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic logic rnd_or_one(input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  function automatic void push(input logic rdy, input logic jam, input state_e st,
                               input logic [20:0] ctl);
    cyc_t c;
    c.rdy = rdy; c.jam = jam; c.st = st; c.ctl = ctl;
    exp_q.push_back(c);
  endfunction

  // Expected per-cycle trace for one instruction starting in FETCH.
  task automatic build(input logic [31:0] ins, input int fs, input int ms, input bit rnd);
    logic [5:0] op;
    op = ins[31:26];
    exp_q.delete();
    for (int i = 0; i < fs; i++)
      push(1'b0, rnd, S_FETCH, pk(0,1,0,0,0,0,2'b00,0,2'b01,6'b100000,0,0,0,0));
    push(1'b1, rnd, S_FETCH, pk(0,1,0,1,1,0,2'b00,0,2'b01,6'b100000,0,0,0,0));
    push(rnd_or_one(rnd), 1'b0, S_DECODE,
         pk(0,0,0,0,0,0,2'b00,0,2'b11,6'b100000,0,0,0,!legal(op)));
    case (op)
      6'h00: begin
        push(rnd_or_one(rnd), 1'b0, S_EXEC_R, pk(0,0,0,0,0,0,2'b00,1,2'b00,ins[5:0],0,0,0,0));
        push(rnd_or_one(rnd), rnd, S_R_WB, pk(0,0,0,0,0,0,2'b00,0,2'b00,6'b0,1,0,1,0));
      end
      6'h23, 6'h2B: begin
        push(rnd_or_one(rnd), rnd, S_MEM_ADDR, pk(0,0,0,0,0,0,2'b00,1,2'b10,6'b100000,0,0,0,0));
        for (int i = 0; i <= ms; i++) begin
          if (op == 6'h23)
            push(i == ms, rnd, S_MEM_RD, pk(1,1,0,0,0,0,2'b00,0,2'b00,6'b0,0,0,0,0));
          else
            push(i == ms, rnd, S_MEM_WR, pk(1,0,1,0,0,0,2'b00,0,2'b00,6'b0,0,0,0,0));
        end
        if (op == 6'h23)
          push(rnd_or_one(rnd), rnd, S_LW_WB, pk(0,0,0,0,0,0,2'b00,0,2'b00,6'b0,0,1,1,0));
      end
      6'h04:
        push(rnd_or_one(rnd), rnd, S_BRANCH, pk(0,0,0,0,0,1,2'b01,1,2'b00,6'b100010,0,0,0,0));
      6'h08: begin
        push(rnd_or_one(rnd), rnd, S_EXEC_I, pk(0,0,0,0,0,0,2'b00,1,2'b10,6'b100000,0,0,0,0));
        push(rnd_or_one(rnd), rnd, S_I_WB, pk(0,0,0,0,0,0,2'b00,0,2'b00,6'b0,0,0,1,0));
      end
      6'h02:
        push(rnd_or_one(rnd), rnd, S_JUMP, pk(0,0,0,0,1,0,2'b10,0,2'b00,6'b0,0,0,0,0));
      default: ;
    endcase
  endtask

  task automatic play(input logic [31:0] ins, input int n);
    foreach (exp_q[i]) begin
      @(negedge Clk);
      MemReady    = exp_q[i].rdy;
      Instruction = exp_q[i].jam ? $urandom : ins;
      ALUZero     = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rnd%0d state c%0d ins %h", n, i, ins), 32'(State), 32'(exp_q[i].st));
      chk($sformatf("rnd%0d ctl c%0d ins %h", n, i, ins), 32'(ctl_w), 32'(exp_q[i].ctl));
    end
  endtask

  // ---------------- table of instruction-level expectations ----------------
  typedef struct {
    logic [31:0] ins;
    int          fs, ms;
    logic        z;
    int          lat, rw, mw, pcw, pcwc, ill;
  } vec_t;

  vec_t tbl[10];

  task automatic measure(input int idx, input vec_t v);
    int n = 0, fc = 0, mc = 0, rw = 0, mw = 0, pcw = 0, pcwc = 0, ill = 0;
    bit left = 0, done = 0;
    Instruction = v.ins;
    ALUZero     = v.z;
    while (!done && n < 40) begin
      @(negedge Clk);
      if (left && State == S_FETCH) begin
        done = 1;
        MemReady = 1'b0;
      end else begin
        if (State == S_FETCH) begin
          MemReady = (fc >= v.fs); fc++;
        end else if (State == S_MEM_RD || State == S_MEM_WR) begin
          MemReady = (mc >= v.ms); mc++;
        end else
          MemReady = 1'b1;
        #1;
        rw   += int'(RegWrite);
        mw   += int'(MemWrite);
        pcw  += int'(PCWrite);
        pcwc += int'(PCWriteCond);
        ill  += int'(IllegalOp);
        if (State != S_FETCH) left = 1;
        n++;
      end
    end
    if (!done) MemReady = 1'b0;
    chk($sformatf("tbl%0d return-to-fetch", idx), 32'(done), 32'd1);
    chk($sformatf("tbl%0d latency", idx), n, v.lat);
    chk($sformatf("tbl%0d RegWrite cycles", idx), rw, v.rw);
    chk($sformatf("tbl%0d MemWrite cycles", idx), mw, v.mw);
    chk($sformatf("tbl%0d PCWrite cycles", idx), pcw, v.pcw);
    chk($sformatf("tbl%0d PCWriteCond cycles", idx), pcwc, v.pcwc);
    chk($sformatf("tbl%0d IllegalOp cycles", idx), ill, v.ill);
  endtask

  initial begin
    logic [31:0] ins, r;
    logic [5:0]  op;
    bit          hit;

    // ins, fs, ms, z, lat, rw, mw, pcw, pcwc, ill
    tbl[0] = '{32'h012A4020, 0, 0, 1'b0, 4, 1, 0, 1, 0, 0};  // R add
    tbl[1] = '{32'h8D090004, 0, 2, 1'b0, 7, 1, 0, 1, 0, 0};  // LW, 2 wait cycles
    tbl[2] = '{32'hAD090004, 0, 0, 1'b0, 4, 0, 1, 1, 0, 0};  // SW
    tbl[3] = '{32'hAD090004, 0, 3, 1'b0, 7, 0, 4, 1, 0, 0};  // SW, 3 wait cycles
    tbl[4] = '{32'h11090003, 0, 0, 1'b1, 3, 0, 0, 1, 1, 0};  // BEQ taken
    tbl[5] = '{32'h11090003, 0, 0, 1'b0, 3, 0, 0, 1, 1, 0};  // BEQ not taken
    tbl[6] = '{32'h21090005, 0, 0, 1'b0, 4, 1, 0, 1, 0, 0};  // ADDI
    tbl[7] = '{32'h08000010, 0, 0, 1'b0, 3, 0, 0, 2, 0, 0};  // J
    tbl[8] = '{32'hFC000000, 0, 0, 1'b0, 2, 0, 0, 1, 0, 1};  // illegal 0x3F
    tbl[9] = '{32'h012A4020, 5, 0, 1'b0, 9, 1, 0, 1, 0, 0};  // R, fetch waits 5

    // Reset state
    #2;
    chk("reset State", 32'(State), 32'd0);
    chk("reset outputs", 32'(ctl_w), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("IDLE->FETCH after release", 32'(State), 32'(S_FETCH));

    // FETCH held by MemReady low: no IR/PC write until the ready cycle
    Instruction = 32'h012A4020;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      MemReady = 1'b0;
      #1;
      chk($sformatf("fetch stall %0d State", i), 32'(State), 32'(S_FETCH));
      chk($sformatf("fetch stall %0d IRWrite", i), 32'(IRWrite), 32'd0);
      chk($sformatf("fetch stall %0d PCWrite", i), 32'(PCWrite), 32'd0);
    end
    @(negedge Clk);
    MemReady = 1'b1;
    #1;
    chk("fetch ready IRWrite", 32'(IRWrite), 32'd1);
    chk("fetch ready PCWrite", 32'(PCWrite), 32'd1);
    @(negedge Clk); #1;
    chk("R DECODE", 32'(State), 32'(S_DECODE));
    @(negedge Clk); #1;
    chk("R EXEC_R", 32'(State), 32'(S_EXEC_R));
    chk("R EXEC_R ALUOp", 32'(ALUOp), 32'h20);
    @(negedge Clk); #1;
    chk("R R_WB", 32'(State), 32'(S_R_WB));
    chk("R R_WB RegWrite/RegDst", 32'({RegWrite, RegDst, MemtoReg}), 32'b110);
    @(negedge Clk);
    MemReady = 1'b0;
    #1;
    chk("R back to FETCH", 32'(State), 32'(S_FETCH));

    // Table-driven instruction runs
    for (int i = 0; i < 10; i++) measure(i, tbl[i]);

    // Reset asserted while a store is waiting in MEM_WR
    Instruction = 32'hAD090004;
    hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge Clk);
      MemReady = (State == S_FETCH);
      #1;
      if (State == S_MEM_WR) hit = 1;
    end
    chk("reached MEM_WR", 32'(hit), 32'd1);
    chk("MEM_WR MemWrite", 32'(MemWrite), 32'd1);
    @(negedge Clk);
    MemReady = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    chk("mid-MEM_WR reset State", 32'(State), 32'd0);
    chk("mid-MEM_WR reset outputs", 32'(ctl_w), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("FETCH after mid-instruction reset", 32'(State), 32'(S_FETCH));

    // Randomized instruction stream against the model
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      case ($urandom_range(0, 7))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      ins = {op, r[25:0]};
      build(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      play(ins, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
